// File: rtl/alsu_pkg.sv
// Shared ALSU definitions: shift engine state encoding and the mode/direction codes
// latched on an accepted start.
package alsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } shift_state_e;

    localparam logic MODE_SHIFT  = 1'b0;
    localparam logic MODE_ROTATE = 1'b1;
    localparam logic DIR_RIGHT   = 1'b0;
    localparam logic DIR_LEFT    = 1'b1;

endpackage

// File: rtl/alsu_shift_engine_if.sv
// Request/result bundle between the ALSU controller (master) and the shift engine (slave).
interface alsu_shift_engine_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
);
    logic             start;
    logic [WIDTH-1:0] load_val;
    logic [CNT_W-1:0] amount;
    logic             mode;
    logic             direction;
    logic             serial_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_shift_reg;

    modport master (
        output start, load_val, amount, mode, direction, serial_in,
        input  busy, done, out_shift_reg
    );

    modport slave (
        input  start, load_val, amount, mode, direction, serial_in,
        output busy, done, out_shift_reg
    );
endinterface

// File: rtl/alsu_shift_step.sv
// Single 1-bit shift/rotate step; serial_in only matters in shift mode.
module alsu_shift_step
    import alsu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] r,
    input  logic             mode,
    input  logic             direction,
    input  logic             serial_in,
    output logic [WIDTH-1:0] next_r
);

    logic fill_left;
    logic fill_right;

    always_comb begin
        fill_left  = (mode == MODE_ROTATE) ? r[WIDTH-1] : serial_in;
        fill_right = (mode == MODE_ROTATE) ? r[0]       : serial_in;
        next_r     = r;
        if (direction == DIR_LEFT) begin
            next_r = {r[WIDTH-2:0], fill_left};
        end else begin
            next_r = {fill_right, r[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alsu_shift_engine.sv
// Multi-cycle shift/rotate engine: loads an operand on start, applies one step per clock
// for 'amount' clocks, then pulses done for one cycle with the result held.
module alsu_shift_engine
    import alsu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    alsu_shift_engine_if.slave  bus
);

    shift_state_e     state;
    shift_state_e     state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] step_r;
    logic             mode_q;
    logic             dir_q;
    logic             accept;

    assign accept = (state == IDLE) && bus.start;

    alsu_shift_step #(.WIDTH(WIDTH)) u_step (
        .r         (shift_r),
        .mode      (mode_q),
        .direction (dir_q),
        .serial_in (bus.serial_in),
        .next_r    (step_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.amount != '0) ? STEP : DONE;
            STEP: if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode only the state register, so nothing combinational reaches them from inputs.
    always_comb begin
        bus.busy = (state != IDLE);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r <= '0;
            cnt     <= '0;
        end else if (accept) begin
            shift_r <= bus.load_val;
            cnt     <= bus.amount;
        end else if (state == STEP) begin
            shift_r <= step_r;
            cnt     <= cnt - CNT_W'(1);
        end
    end

    // Operation attributes are frozen at accept so mid-operation input changes are inert.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q <= bus.mode;
            dir_q  <= bus.direction;
        end
    end

    assign bus.out_shift_reg = shift_r;

endmodule

// File: tb/tb_alsu_shift_engine.sv
// Directed-vector bench for alsu_shift_engine with hand-computed expected results.
module tb_alsu_shift_engine;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alsu_shift_engine_if #(.WIDTH(6), .CNT_W(3)) bus ();

    alsu_shift_engine #(.WIDTH(6), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for exactly one edge (E); returns just after E.
    task automatic issue(input logic [5:0] v, input logic [2:0] amt,
                         input logic m, input logic d, input logic si);
        bus.load_val  = v;
        bus.amount    = amt;
        bus.mode      = m;
        bus.direction = d;
        bus.serial_in = si;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Edges counted from start assertion until done is seen; -1 if it never arrives.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            if (bus.done === 1'b1) begin
                cyc = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nvec++; if (bus.out_shift_reg !== 6'b000000) begin nerr++; $display("FAIL reset_out: got %b want %b", bus.out_shift_reg, 6'b000000); end
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL idle_quiet[%0d]: done %b busy %b want 0 0", i, bus.done, bus.busy); end
        end
        nvec++; if (bus.out_shift_reg !== 6'b000000) begin nerr++; $display("FAIL idle_out: got %b want %b", bus.out_shift_reg, 6'b000000); end
    endtask

    task automatic test_shift_left();
        int cyc;
        issue(6'b000101, 3'd2, 1'b0, 1'b1, 1'b1);
        nvec++; if (bus.busy !== 1'b1 || bus.out_shift_reg !== 6'b000101) begin nerr++; $display("FAIL shl_load: busy %b out %b want 1 000101", bus.busy, bus.out_shift_reg); end
        wait_done(cyc);
        nvec++; if (cyc !== 3) begin nerr++; $display("FAIL shl_latency: got %0d want 3", cyc); end
        nvec++; if (bus.out_shift_reg !== 6'b010111) begin nerr++; $display("FAIL shl_result: got %b want 010111", bus.out_shift_reg); end
        tick();
        nvec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_shift_reg !== 6'b010111) begin nerr++; $display("FAIL shl_idle: busy %b done %b out %b want 0 0 010111", bus.busy, bus.done, bus.out_shift_reg); end
        issue(6'b000000, 3'd7, 1'b0, 1'b1, 1'b1);
        wait_done(cyc);
        nvec++; if (cyc !== 8 || bus.out_shift_reg !== 6'b111111) begin nerr++; $display("FAIL shl_by7: cyc %0d out %b want 8 111111", cyc, bus.out_shift_reg); end
        tick();
    endtask

    task automatic test_rotate_right();
        int cyc;
        issue(6'b000001, 3'd1, 1'b1, 1'b0, 1'b0);
        wait_done(cyc);
        nvec++; if (cyc !== 2 || bus.out_shift_reg !== 6'b100000) begin nerr++; $display("FAIL ror1: cyc %0d out %b want 2 100000", cyc, bus.out_shift_reg); end
        tick();
        issue(6'b000001, 3'd6, 1'b1, 1'b0, 1'b1);
        wait_done(cyc);
        nvec++; if (cyc !== 7 || bus.out_shift_reg !== 6'b000001) begin nerr++; $display("FAIL ror6: cyc %0d out %b want 7 000001", cyc, bus.out_shift_reg); end
        tick();
    endtask

    task automatic test_amount_zero_busy_start();
        int cyc;
        issue(6'b101010, 3'd0, 1'b0, 1'b0, 1'b0);
        bus.load_val = 6'b010101;
        bus.amount   = 3'd2;
        bus.start    = 1'b1;
        wait_done(cyc);
        nvec++; if (cyc !== 1 || bus.out_shift_reg !== 6'b101010) begin nerr++; $display("FAIL amt0: cyc %0d out %b want 1 101010", cyc, bus.out_shift_reg); end
        tick();
        bus.start = 1'b0;
        nvec++; if (bus.busy !== 1'b0 || bus.out_shift_reg !== 6'b101010) begin nerr++; $display("FAIL start_in_done: busy %b out %b want 0 101010", bus.busy, bus.out_shift_reg); end
        tick();
        nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL start_not_queued: busy %b want 0", bus.busy); end
        issue(6'b000011, 3'd3, 1'b1, 1'b1, 1'b0);
        bus.load_val  = 6'b111000;
        bus.amount    = 3'd0;
        bus.mode      = 1'b0;
        bus.direction = 1'b0;
        bus.start     = 1'b1;
        wait_done(cyc);
        bus.start = 1'b0;
        nvec++; if (cyc !== 4 || bus.out_shift_reg !== 6'b011000) begin nerr++; $display("FAIL start_in_step: cyc %0d out %b want 4 011000", cyc, bus.out_shift_reg); end
        tick();
    endtask

    task automatic test_reset_mid_step();
        int cyc;
        issue(6'b110011, 3'd5, 1'b0, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nvec++; if (bus.busy !== 1'b0 || bus.out_shift_reg !== 6'b000000 || bus.done !== 1'b0) begin nerr++; $display("FAIL mid_reset: busy %b done %b out %b want 0 0 000000", bus.busy, bus.done, bus.out_shift_reg); end
        for (int i = 0; i < 6; i++) begin
            tick();
            nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL mid_reset_nodone[%0d]: done %b want 0", i, bus.done); end
        end
        issue(6'b110011, 3'd1, 1'b0, 1'b0, 1'b0);
        wait_done(cyc);
        nvec++; if (cyc !== 2 || bus.out_shift_reg !== 6'b011001) begin nerr++; $display("FAIL after_reset: cyc %0d out %b want 2 011001", cyc, bus.out_shift_reg); end
        tick();
    endtask

    task automatic test_serial_toggle();
        issue(6'b111111, 3'd3, 1'b0, 1'b0, 1'b0);
        bus.serial_in = 1'b1;
        tick();
        bus.serial_in = 1'b0;
        tick();
        bus.serial_in = 1'b1;
        tick();
        nvec++; if (bus.done !== 1'b1 || bus.out_shift_reg !== 6'b101111) begin nerr++; $display("FAIL shr_serial: done %b out %b want 1 101111", bus.done, bus.out_shift_reg); end
        tick();
        nvec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin nerr++; $display("FAIL shr_serial_idle: busy %b done %b want 0 0", bus.busy, bus.done); end
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.load_val  = '0;
        bus.amount    = '0;
        bus.mode      = 1'b0;
        bus.direction = 1'b0;
        bus.serial_in = 1'b0;
        test_reset();
        test_shift_left();
        test_rotate_right();
        test_amount_zero_busy_start();
        test_reset_mid_step();
        test_serial_toggle();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alsu_shift_engine.md
# alsu_shift_engine

Multi-step shift/rotate engine that produces `out_shift_reg`, the shift/rotate result the ALSU registers for opcodes 4 and 5. A start pulse loads an operand. The engine then applies `amount` single-bit shift or rotate steps, one per clock, and pulses `done` when the result is stable. It sits beside the ALSU on the same clock and reset. The ALSU-side controller drives start and then reads the result.

## Interface
- `WIDTH`, 6: data width; matches the ALSU `out` width.
- `CNT_W`, 3: width of the step-count field.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the `clk` rising edge.
- `start`  in  1: request; honoured only in IDLE.
- `load_val`  in  WIDTH: operand captured on the accepted start.
- `amount`  in  CNT_W: number of 1-bit steps, 0..7; captured on the accepted start.
- `mode`  in  1: 0 = shift, 1 = rotate; captured on the accepted start.
- `direction`  in  1: 1 = left, 0 = right; captured on the accepted start.
- `serial_in`  in  1: fill bit for shift mode; sampled live on every step edge, not captured.
- `busy`  out  1: high whenever state is not IDLE.
- `done`  out  1: one-cycle pulse; `out_shift_reg` is final while it is high.
- `out_shift_reg`  out  WIDTH: working/result register.

## Operation
- **States:**
  - IDLE: `busy`=0.
  - STEP: one step per edge; `busy`=1.
  - DONE: `done`=1, `busy`=1.
- **IDLE + start:**
  - Load `out_shift_reg`←`load_val` and `cnt`←`amount`.
  - Latch `mode` and `direction`.
  - Next state is STEP if `amount`≠0, otherwise DONE.
- **STEP:** each edge applies one step and decrements `cnt`. When `cnt`==1 at the edge, the next state is DONE.
- **Step rules, with r = `out_shift_reg`:**
  - shift left: {r[WIDTH-2:0], `serial_in`}.
  - shift right: {`serial_in`, r[WIDTH-1:1]}.
  - rotate left: {r[WIDTH-2:0], r[WIDTH-1]}.
  - rotate right: {r[0], r[WIDTH-1:1]}.
- **DONE:** unconditionally returns to IDLE on the next edge. `out_shift_reg` holds its value in DONE and in IDLE until the next accepted start.
- **start while busy:** ignored, not queued. Inputs changing mid-operation have no effect, except `serial_in`.
- **start in DONE:** ignored. A back-to-back request must be asserted in IDLE, so the minimum issue interval is `amount`+2 cycles.
- **Amount ≥ WIDTH:** legal.
  - Rotating by WIDTH returns the operand unchanged.
  - Shifting by ≥WIDTH leaves only `serial_in` history in the register.
- **Reset**, at any time including mid-STEP: next edge gives state IDLE, `out_shift_reg`=0, `cnt`=0, `busy`=0, `done`=0. Reset has priority over start on the same edge.

## Timing
- Reset values: `out_shift_reg`=0, `busy`=0, `done`=0, state IDLE.
- start sampled high at edge E in IDLE:
  - Load at E; `busy` rises after E.
  - Steps occur at edges E+1 .. E+`amount`.
  - `done` is high for exactly one cycle, following edge E+`amount`.
  - State returns to IDLE at edge E+`amount`+1.
- `amount`=0: `done` is high in the cycle after E, and `out_shift_reg`=`load_val`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `alsu_pkg` holds:
  - the state enum `shift_state_e` {IDLE, STEP, DONE};
  - mode constants `MODE_SHIFT`=0 and `MODE_ROTATE`=1;
  - direction constants `DIR_RIGHT`=0 and `DIR_LEFT`=1.
- One combinational sub-module, `alsu_shift_step` (r, mode, direction, serial_in → next_r), implements the single-step rules. The FSM and counter live in the top module.

## Test plan
- Reset, then idle 3 cycles → `out_shift_reg`=0, `busy`=0, `done` never asserted.
- Shift left: start with `load_val`=6'b000101, `amount`=2, `mode`=0, `direction`=1, `serial_in`=1 → `done` 3 cycles after start with `out_shift_reg`=6'b010111.
- Rotate right: `load_val`=6'b000001, `amount`=1 → 6'b100000. Repeat with `amount`=6 → 6'b000001 after 7 cycles.
- `amount`=0 with `load_val`=6'b101010 → `done` 1 cycle after start, value 6'b101010. A second start asserted while `busy`, with a different `load_val`, is ignored.
- Reset asserted at the second STEP edge of an `amount`=5 shift → next cycle `busy`=0, `out_shift_reg`=0, no `done` pulse. A fresh start afterwards completes normally.
- Shift right with `serial_in` toggling 1,0,1 on successive step edges, `load_val`=6'b111111, `amount`=3 → 6'b101111.
